// File: rtl/fetch_pkg.sv
// Fetch-stage local types.
package fetch_pkg;
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} fetch_state_t;
endpackage

// File: rtl/rv_pkg.sv
// Core-wide constants shared by the RV64 multicycle datapath and control unit.
package rv_pkg;
    localparam int          XLEN      = 64;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
endpackage

// File: rtl/pc_reg.sv
// Architectural PC register with the control unit's write/branch-take decision.
module pc_reg #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_write,
    input  logic            pc_write_cond,
    input  logic            branch_op,
    input  logic            pc_src,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] alu_out,
    input  logic            alu_zero,
    output logic [XLEN-1:0] pc
);
    logic            w_take;
    logic [XLEN-1:0] w_next;
    logic [XLEN-1:0] r_pc;

    // branch_op flips the sense of the zero flag: beq takes on zero, bne on nonzero
    assign w_take = pc_write | (pc_write_cond & (alu_zero ^ branch_op));
    assign w_next = pc_src ? alu_out : alu_result;

    always_ff @(posedge clk) begin
        if (!rst_n)      r_pc <= RESET_PC;
        else if (w_take) r_pc <= w_next;
    end

    assign pc = r_pc;
endmodule

// File: rtl/fetch_unit.sv
// PC + instruction fetch stage: single outstanding request to imem, IR capture.
module fetch_unit
    import rv_pkg::*;
    import fetch_pkg::*;
#(
    parameter int              XLEN     = rv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              IMEM_AW  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_start,
    input  logic               pc_write,
    input  logic               pc_write_cond,
    input  logic               branch_op,
    input  logic               pc_src,
    input  logic [XLEN-1:0]    alu_result,
    input  logic [XLEN-1:0]    alu_out,
    input  logic               alu_zero,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_rvalid,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        instruction,
    output logic               instr_valid,
    output logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    pc_cur,
    output logic               fetch_busy,
    output logic               misaligned_fault
);
    fetch_state_t       r_state, w_state_nxt;
    logic               r_req, w_req_nxt;
    logic [IMEM_AW-1:0] r_addr, w_addr_nxt;
    logic [31:0]        r_ir, w_ir_nxt;
    logic               r_ivalid, w_ivalid_nxt;
    logic [XLEN-1:0]    r_pc_cur, w_pc_cur_nxt;
    logic               r_fault, w_fault_nxt;
    logic [XLEN-1:0]    w_pc;

    pc_reg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .branch_op    (branch_op),
        .pc_src       (pc_src),
        .alu_result   (alu_result),
        .alu_out      (alu_out),
        .alu_zero     (alu_zero),
        .pc           (w_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_req    <= 1'b0;
            r_addr   <= '0;
            r_ir     <= NOP_INSTR;
            r_ivalid <= 1'b0;
            r_pc_cur <= RESET_PC;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_req    <= w_req_nxt;
            r_addr   <= w_addr_nxt;
            r_ir     <= w_ir_nxt;
            r_ivalid <= w_ivalid_nxt;
            r_pc_cur <= w_pc_cur_nxt;
            r_fault  <= w_fault_nxt;
        end
    end

    // The request samples the pre-edge PC, so a same-cycle PC write (PC+4) never
    // disturbs the fetch it accompanies or one already in flight.
    always_comb begin
        w_state_nxt  = r_state;
        w_req_nxt    = r_req;
        w_addr_nxt   = r_addr;
        w_ir_nxt     = r_ir;
        w_ivalid_nxt = r_ivalid;
        w_pc_cur_nxt = r_pc_cur;
        w_fault_nxt  = r_fault;
        case (r_state)
            IDLE: begin
                if (fetch_start) begin
                    w_ivalid_nxt = 1'b0;
                    if (w_pc[1:0] == 2'b00) begin
                        w_state_nxt  = WAIT;
                        w_req_nxt    = 1'b1;
                        w_addr_nxt   = w_pc[IMEM_AW-1:0];
                        w_pc_cur_nxt = w_pc;
                        w_fault_nxt  = 1'b0;
                    end else begin
                        w_fault_nxt  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    w_state_nxt  = IDLE;
                    w_req_nxt    = 1'b0;
                    w_ir_nxt     = imem_rdata;
                    w_ivalid_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign imem_req         = r_req;
    assign imem_addr        = r_addr;
    assign instruction      = r_ir;
    assign instr_valid      = r_ivalid;
    assign pc               = w_pc;
    assign pc_cur           = r_pc_cur;
    assign fetch_busy       = (r_state == WAIT);
    assign misaligned_fault = r_fault;
endmodule

// File: tb/tb_fetch_unit.sv
// Fetch unit bench: directed scenarios plus random traffic against a transaction-level model.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_start, pc_write, pc_write_cond, branch_op, pc_src, alu_zero;
    logic [63:0] alu_result, alu_out;
    logic        imem_req, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata, instruction;
    logic        instr_valid, fetch_busy, misaligned_fault;
    logic [63:0] pc, pc_cur;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // model: one outstanding fetch, tracked as a transaction
    logic [63:0] m_pc, m_pc_cur;
    logic [31:0] m_ir, m_addr;
    bit          m_outstanding, m_ivalid, m_fault;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .branch_op(branch_op), .pc_src(pc_src),
        .alu_result(alu_result), .alu_out(alu_out), .alu_zero(alu_zero),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .instruction(instruction), .instr_valid(instr_valid),
        .pc(pc), .pc_cur(pc_cur), .fetch_busy(fetch_busy), .misaligned_fault(misaligned_fault)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [63:0] pc_before;
        bit          take;
        pc_before = m_pc;
        if (!rst_n) begin
            m_pc = 64'h0; m_pc_cur = 64'h0; m_ir = 32'h13; m_addr = 32'h0;
            m_outstanding = 0; m_ivalid = 0; m_fault = 0;
            return;
        end
        take = pc_write || (pc_write_cond && (branch_op ? !alu_zero : alu_zero));
        if (take) m_pc = pc_src ? alu_out : alu_result;
        if (m_outstanding) begin
            if (imem_rvalid) begin
                m_ir = imem_rdata; m_ivalid = 1; m_outstanding = 0;
            end
        end else if (fetch_start) begin
            m_ivalid = 0;
            if (pc_before % 4 == 0) begin
                m_outstanding = 1; m_addr = pc_before[31:0]; m_pc_cur = pc_before; m_fault = 0;
            end else begin
                m_fault = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("pc", pc, m_pc);
            check("pc_cur", pc_cur, m_pc_cur);
            check("instruction", {32'h0, instruction}, {32'h0, m_ir});
            check("instr_valid", {63'h0, instr_valid}, {63'h0, m_ivalid});
            check("imem_req", {63'h0, imem_req}, {63'h0, m_outstanding});
            check("fetch_busy", {63'h0, fetch_busy}, {63'h0, m_outstanding});
            check("misaligned_fault", {63'h0, misaligned_fault}, {63'h0, m_fault});
            if (m_outstanding) check("imem_addr", {32'h0, imem_addr}, {32'h0, m_addr});
        end
    end

    task automatic idle_inputs();
        fetch_start = 0; pc_write = 0; pc_write_cond = 0; branch_op = 0; pc_src = 0;
        alu_zero = 0; alu_result = 0; alu_out = 0; imem_rvalid = 0; imem_rdata = 0;
    endtask

    function automatic logic [63:0] rand_pc();
        logic [63:0] v;
        v = {32'h0, $urandom} & 64'hFFFF_FFFF_0000_FFFC;
        if ($urandom_range(0, 7) == 0) v[1:0] = 2'($urandom_range(1, 3));
        return v;
    endfunction

    int rises;
    bit prev_v;

    initial begin
        idle_inputs();
        rst_n = 0;
        @(negedge clk);
        tick(); tick();
        rst_n = 1;
        chk_en = 1;
        check("rst_pc", pc, 64'h0);
        check("rst_ir", {32'h0, instruction}, 64'h13);
        check("rst_ivalid", {63'h0, instr_valid}, 64'h0);
        check("rst_req", {63'h0, imem_req}, 64'h0);

        // 1: fastest fetch
        fetch_start = 1; tick(); fetch_start = 0;
        check("t1_req", {63'h0, imem_req}, 64'h1);
        check("t1_addr", {32'h0, imem_addr}, 64'h0);
        imem_rvalid = 1; imem_rdata = 32'h00A00093; tick(); imem_rvalid = 0;
        check("t1_ivalid", {63'h0, instr_valid}, 64'h1);
        check("t1_ir", {32'h0, instruction}, 64'h00A00093);
        check("t1_pc_cur", pc_cur, 64'h0);

        // 2: fetch with PC+4 write, slow memory
        fetch_start = 1; pc_write = 1; pc_src = 0; alu_result = 64'h4; tick();
        fetch_start = 0; pc_write = 0;
        check("t2_pc", pc, 64'h4);
        for (int i = 0; i < 3; i++) begin
            check("t2_req_held", {63'h0, imem_req}, 64'h1);
            check("t2_addr_held", {32'h0, imem_addr}, 64'h0);
            check("t2_ivalid_low", {63'h0, instr_valid}, 64'h0);
            tick();
        end
        check("t2_req_4th", {63'h0, imem_req}, 64'h1);
        imem_rvalid = 1; imem_rdata = 32'h00100113; tick(); imem_rvalid = 0;
        check("t2_ivalid", {63'h0, instr_valid}, 64'h1);
        check("t2_req_drop", {63'h0, imem_req}, 64'h0);

        // 3: conditional branches
        pc_write_cond = 1; branch_op = 0; pc_src = 1; alu_out = 64'h40; alu_zero = 1; tick();
        check("t3_beq_taken", pc, 64'h40);
        alu_out = 64'h80; alu_zero = 0; tick();
        check("t3_beq_not", pc, 64'h40);
        branch_op = 1; alu_out = 64'hC0; alu_zero = 0; tick();
        check("t3_bne_taken", pc, 64'hC0);
        pc_write_cond = 0; branch_op = 0;

        // 4: misaligned fetch
        pc_write = 1; pc_src = 1; alu_out = 64'h42; tick(); pc_write = 0;
        fetch_start = 1; tick(); fetch_start = 0;
        check("t4_no_req", {63'h0, imem_req}, 64'h0);
        check("t4_fault", {63'h0, misaligned_fault}, 64'h1);
        check("t4_ivalid", {63'h0, instr_valid}, 64'h0);
        pc_write = 1; alu_out = 64'h100; tick(); pc_write = 0;
        check("t4_sticky", {63'h0, misaligned_fault}, 64'h1);
        fetch_start = 1; tick(); fetch_start = 0;
        check("t4_cleared", {63'h0, misaligned_fault}, 64'h0);
        check("t4_addr", {32'h0, imem_addr}, 64'h100);
        imem_rvalid = 1; imem_rdata = 32'h12345678; tick(); imem_rvalid = 0;

        // 5: reset mid-fetch, late response ignored
        fetch_start = 1; tick(); fetch_start = 0;
        rst_n = 0; tick(); rst_n = 1;
        imem_rvalid = 1; imem_rdata = 32'hDEADBEEF; tick(); imem_rvalid = 0;
        check("t5_req", {63'h0, imem_req}, 64'h0);
        check("t5_pc", pc, 64'h0);
        check("t5_ir", {32'h0, instruction}, 64'h13);
        check("t5_ivalid", {63'h0, instr_valid}, 64'h0);

        // 6: fetch_start during WAIT is dropped
        rises = 0; prev_v = instr_valid;
        fetch_start = 1; tick();
        pc_write = 1; pc_src = 0; alu_result = 64'h8; tick(); pc_write = 0;
        check("t6_addr_kept", {32'h0, imem_addr}, 64'h0);
        fetch_start = 0;
        imem_rvalid = 1; imem_rdata = 32'h00000073;
        for (int i = 0; i < 4; i++) begin
            tick();
            imem_rvalid = 0;
            if (instr_valid && !prev_v) rises++;
            prev_v = instr_valid;
        end
        check("t6_one_rise", 64'(rises), 64'h1);
        check("t6_req_idle", {63'h0, imem_req}, 64'h0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            rst_n         = ($urandom_range(0, 99) != 0);
            fetch_start   = ($urandom_range(0, 2) == 0);
            pc_write      = ($urandom_range(0, 5) == 0);
            pc_write_cond = ($urandom_range(0, 5) == 0);
            branch_op     = 1'($urandom);
            pc_src        = 1'($urandom);
            alu_zero      = 1'($urandom);
            alu_result    = rand_pc();
            alu_out       = rand_pc();
            imem_rvalid   = ($urandom_range(0, 2) == 0);
            imem_rdata    = $urandom;
            tick();
        end
        idle_inputs();
        rst_n = 1;
        tick();
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
